instr_fetch: RTL and testbench

Instruction fetch unit for the 8-bit microprocessor. It sits between the PC counter and program memory. It reads the current PC, issues one read at a time to program memory over a req/ack handshake, and pulses a step strobe so the PC counter advances. Fetched bytes are buffered, tagged with their address, in a small FIFO toward the decoder. A branch flush discards buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state type,
// default bus widths and the bit positions inside the flags output.
package fetch_pkg;

  // Fetch controller states.
  //   IDLE  : no request, waiting for FIFO space
  //   REQ   : read outstanding, result will be kept
  //   STEP  : result pushed, PC counter is told to advance
  //   DRAIN : read outstanding after a flush, result will be dropped
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STEP  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int unsigned FETCH_ADDR_W = 8;
  localparam int unsigned FETCH_DATA_W = 8;

  // Bit positions of the status flags.
  localparam int unsigned FLAG_FULL  = 1;
  localparam int unsigned FLAG_EMPTY = 0;

  // A memory read is outstanding in both REQ and DRAIN.
  function automatic logic mem_busy(input fetch_state_e s);
    return (s == REQ) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {address, instruction} entries feeding the decoder.
// The head entry is read straight from the storage registers, so its
// outputs carry no combinational path from push/pop/clear.
module fetch_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clear,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Never pop an empty FIFO; a push into a full FIFO is only legal
  // when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_mem[PTR_W'(i)] <= '0;
        data_mem[PTR_W'(i)] <= '0;
      end
    end else if (do_push && !clear) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one program-memory read at a time from
// the current PC, strobes the PC counter after each kept fetch and queues
// fetched bytes with their address toward the decoder. A flush drops all
// queued entries and discards the result of any read still in flight.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pcStep,
  input  logic              flush,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic              instrValid,
  input  logic              instrReady,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instrAddr,
  output logic [1:0]        flags
);

  fetch_state_e state;
  fetch_state_e state_nxt;
  logic         issue;
  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;

  // Next-state decode. Issuing only while the FIFO has room, with a
  // single read in flight, is what makes overflow impossible.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_full && !flush) begin
          state_nxt = REQ;
          issue     = 1'b1;
        end
      end
      REQ: begin
        if (memAck) begin
          state_nxt = flush ? IDLE : STEP;
          push      = !flush;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      STEP:    state_nxt = IDLE;
      DRAIN: begin
        if (memAck) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read address is captured at issue and held until the read completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memAddr <= '0;
    end else if (issue) begin
      memAddr <= pc;
    end
  end

  assign memReq = mem_busy(state);

  // The step strobe is gated by flush in the STEP cycle because the PC
  // counter is loading the branch target on that edge instead.
  assign pcStep = (state == STEP) && !flush;

  // A pop coinciding with a flush is ignored; the clear takes care of it.
  assign pop = instrValid && instrReady && !flush;

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (memAddr),
    .push_data (memData),
    .pop       (pop),
    .clear     (flush),
    .head_addr (instrAddr),
    .head_data (instr),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instrValid        = !fifo_empty;
  assign flags[FLAG_FULL]  = fifo_full;
  assign flags[FLAG_EMPTY] = fifo_empty;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a queue-based model of the fetch unit, a PC
// counter and a latency-programmable memory surround the design; a
// compare process checks every cycle and the directed sequence adds
// hand-computed expectations at the interesting points.
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pc = 8'h00;
  logic       pcStep;
  logic       flush = 1'b0;
  logic       memReq;
  logic [7:0] memAddr;
  logic       memAck = 1'b0;
  logic [7:0] memData = 8'h00;
  logic       instrValid;
  logic       instrReady = 1'b0;
  logic [7:0] instr;
  logic [7:0] instrAddr;
  logic [1:0] flags;

  int checks = 0;
  int errors = 0;

  // environment controls
  int         lat = 0;
  logic [7:0] branch_pc = 8'h00;
  logic       preset_en = 1'b1;
  logic [7:0] mem [256];
  int         wcnt = 0;

  // model state
  logic [15:0] mq[$];
  logic        m_busy = 1'b0;
  logic        m_drop = 1'b0;
  logic        m_step = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic        md_fl, md_st, md_push;

  instr_fetch #(
    .DEPTH  (DEPTH),
    .ADDR_W (8),
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .pcStep     (pcStep),
    .flush      (flush),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memAck     (memAck),
    .memData    (memData),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .instr      (instr),
    .instrAddr  (instrAddr),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: acknowledges the lat-th cycle after the request is seen.
  always @(negedge clk) begin
    #1;
    if (!reset || !memReq) begin
      wcnt = 0; memAck = 1'b0; memData = 8'h00;
    end else if (memAck) begin
      wcnt = 0; memAck = 1'b0; memData = 8'h00;
    end else if (wcnt >= lat) begin
      memAck = 1'b1; memData = mem[memAddr];
    end else begin
      wcnt++;
    end
  end

  // Model of the fetch unit plus the PC counter, advanced on each edge.
  always @(posedge clk) begin
    md_fl   = flush;
    md_st   = m_step && !flush && reset;
    md_push = 1'b0;
    if (!reset) begin
      mq.delete();
      m_busy = 1'b0; m_drop = 1'b0; m_step = 1'b0; m_addr = 8'h00;
    end else begin
      if (m_busy) begin
        if (memAck) begin
          m_busy = 1'b0;
          if (!m_drop && !flush) begin
            md_push = 1'b1;
            m_step  = 1'b1;
          end
          m_drop = 1'b0;
        end else if (flush) begin
          m_drop = 1'b1;
        end
      end else if (m_step) begin
        m_step = 1'b0;
      end else if (mq.size() < DEPTH && !flush) begin
        m_busy = 1'b1;
        m_addr = pc;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && instrReady) void'(mq.pop_front());
        if (md_push) mq.push_back({m_addr, mem[m_addr]});
      end
    end
    #1;
    if (md_fl || (preset_en && !reset)) pc = branch_pc;
    else if (md_st) pc = pc + 8'd1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      check("rst_memReq", memReq, 0);
      check("rst_memAddr", memAddr, 0);
      check("rst_pcStep", pcStep, 0);
      check("rst_instrValid", instrValid, 0);
      check("rst_instr", instr, 0);
      check("rst_instrAddr", instrAddr, 0);
      check("rst_flags", flags, 2'b01);
    end else begin
      check("memReq", memReq, m_busy);
      check("memAddr", memAddr, m_addr);
      check("pcStep", pcStep, m_step && !flush);
      check("instrValid", instrValid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("instr", instr, mq[0][7:0]);
        check("instrAddr", instrAddr, mq[0][15:8]);
      end
      check("flags", flags, {mq.size() == DEPTH, mq.size() == 0});
    end
  end

  task automatic do_reset(input logic [7:0] start);
    @(negedge clk);
    reset = 1'b0; preset_en = 1'b1; branch_pc = start; flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; preset_en = 1'b0;
  endtask

  // which: 0 memReq, 1 instrValid, 2 pcStep. Bounded wait at negedges.
  task automatic wait_sig(input int which, input string name);
    logic c;
    c = 1'b0;
    for (int i = 0; i < 30; i++) begin
      c = (which == 0) ? memReq : (which == 1) ? instrValid : pcStep;
      if (c) break;
      @(negedge clk);
    end
    check(name, c, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 1);
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h77;

    // Reset held with random inputs
    repeat (3) begin
      @(negedge clk);
      branch_pc  = 8'($urandom);
      flush      = 1'($urandom);
      instrReady = 1'($urandom);
    end
    #3;
    check("t1_flags", flags, 2'b01);
    check("t1_memReq", memReq, 0);

    // Basic fetch at 0x10, ack two cycles after memReq rises
    @(negedge clk);
    flush = 1'b0; instrReady = 1'b0; branch_pc = 8'h10; lat = 2;
    @(negedge clk);
    reset = 1'b1; preset_en = 1'b0;
    #3;
    check("t2_idle_after_release", memReq, 0);
    @(negedge clk);
    #3;
    check("t2_req", memReq, 1);
    check("t2_addr", memAddr, 8'h10);
    wait_sig(1, "t2_wait_valid");
    #3;
    check("t2_instr", instr, 8'hA5);
    check("t2_instrAddr", instrAddr, 8'h10);
    check("t2_step", pcStep, 1);
    @(negedge clk);
    #3;
    check("t2_step_one_cycle", pcStep, 0);

    // Fill with wrap: 0xFE, 0xFF then drain, next fetch at 0x00
    lat = 0; instrReady = 1'b0;
    do_reset(8'hFE);
    repeat (8) @(negedge clk);
    #3;
    check("t3_full_flags", flags, 2'b10);
    check("t3_no_req", memReq, 0);
    check("t3_head_addr", instrAddr, 8'hFE);
    check("t3_head_instr", instr, 8'hFB);
    instrReady = 1'b1;
    @(negedge clk);
    #3;
    check("t3_second_addr", instrAddr, 8'hFF);
    check("t3_second_instr", instr, 8'hFE);
    check("t3_one_flags", flags, 2'b00);
    @(negedge clk);
    #3;
    check("t3_wrap_req", memReq, 1);
    check("t3_wrap_addr", memAddr, 8'h00);
    @(negedge clk);
    #3;
    check("t3_wrap_instr", instr, 8'h01);

    // Flush in REQ cycle 2, ack 3 cycles later
    lat = 4;
    do_reset(8'h30);
    branch_pc = 8'h40;
    wait_sig(0, "t4_wait_req");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("t4_req_held", memReq, 1);
      check("t4_addr_held", memAddr, 8'h30);
      check("t4_no_valid", instrValid, 0);
      @(negedge clk);
    end
    #3;
    check("t4_after_ack_req", memReq, 0);
    check("t4_after_ack_valid", instrValid, 0);
    check("t4_after_ack_step", pcStep, 0);
    @(negedge clk);
    #3;
    check("t4_new_req", memReq, 1);
    check("t4_new_addr", memAddr, 8'h40);

    // Flush together with memAck, one entry queued, decoder ready
    lat = 1; instrReady = 1'b0;
    do_reset(8'h50);
    wait_sig(1, "t5a_wait_valid");
    wait_sig(0, "t5a_wait_req");
    @(negedge clk);
    flush = 1'b1; instrReady = 1'b1; branch_pc = 8'h60;
    #3;
    check("t5a_step_in_flush", pcStep, 0);
    @(negedge clk);
    flush = 1'b0; instrReady = 1'b0;
    #3;
    check("t5a_cleared_valid", instrValid, 0);
    check("t5a_cleared_flags", flags, 2'b01);
    check("t5a_no_step", pcStep, 0);
    check("t5a_no_req", memReq, 0);
    @(negedge clk);
    #3;
    check("t5a_new_addr", memAddr, 8'h60);

    // Flush during STEP with entries queued
    wait_sig(2, "t5b_wait_step1");
    @(negedge clk);
    wait_sig(2, "t5b_wait_step2");
    flush = 1'b1; instrReady = 1'b1; branch_pc = 8'h70;
    #3;
    check("t5b_step_forced_low", pcStep, 0);
    @(negedge clk);
    flush = 1'b0; instrReady = 1'b0; lat = 0;
    #3;
    check("t5b_cleared_valid", instrValid, 0);
    check("t5b_cleared_flags", flags, 2'b01);
    @(negedge clk);
    #3;
    check("t5b_new_addr", memAddr, 8'h70);

    // Reset during REQ with one entry queued
    @(negedge clk);
    lat = 3;
    wait_sig(0, "t6_wait_req");
    check("t6_queued", instrValid, 1);
    @(negedge clk);
    reset = 1'b0;
    #3;
    check("t6_req_drop", memReq, 0);
    check("t6_valid_drop", instrValid, 0);
    check("t6_step_low", pcStep, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_sig(0, "t6_resume_req");
    #3;
    check("t6_resume_addr", memAddr, 8'h71);
    wait_sig(1, "t6_resume_valid");
    #3;
    check("t6_resume_instr", instr, 8'h54);
    check("t6_resume_instrAddr", instrAddr, 8'h71);

    repeat (3) @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
